// File: rtl/word_arb_pkg.sv
// ---------------------------------------------------------------------------
// word_arb_pkg
//
// Shared definitions for the word sink arbiter:
//   arb_state_t    - arbiter FSM state (IDLE between grants, BURST while a
//                    source owns the sink)
//   DEF_NREQ       - default number of word sources
//   DEF_DW         - default data word width
//   DEF_MAX_BURST  - default maximum words forwarded per grant
// ---------------------------------------------------------------------------
package word_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DW        = 16;
    localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/word_sink_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin first-set finder. Starting at position ptr and
// walking upward modulo NREQ, reports the first set bit of req.
//
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  TW    starting position of the search (0..NREQ-1)
//   any  out 1     at least one request bit is set
//   idx  out TW    index of the first set bit at or after ptr (0 if none)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TW-1:0]   ptr,
    output logic            any,
    output logic [TW-1:0]   idx
);

    // The first hit wins; later hits are ignored once any is set, which
    // gives the priority order ptr, ptr+1, ..., wrapping through NREQ-1.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!any && req[(32'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = TW'((32'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/word_sink_arbiter.sv
// ---------------------------------------------------------------------------
// word_sink_arbiter
//
// Shares one DW-bit word sink between NREQ independent word sources. One
// source is granted at a time for a burst that ends on its src_last marker
// or after MAX_BURST words, whichever comes first. Granted words pass
// through a single registered output stage carrying the source tag.
// Successive grants rotate round-robin starting after the last winner.
//
// Ports:
//   clk        in   1        clock, all state on rising edge
//   rstb       in   1        asynchronous active-low reset
//   enable     in   1        global gate; low blocks new grants and accepts
//   src_valid  in   NREQ     per-source word valid
//   src_last   in   NREQ     per-source end-of-packet, qualified by valid
//   src_data   in   NREQ*DW  packed source words, source i at [i*DW +: DW]
//   src_ready  out  NREQ     per-source accept, at most one bit set
//   snk_valid  out  1        registered output word valid
//   snk_ready  in   1        sink accept
//   snk_data   out  DW       registered output word
//   snk_tag    out  TW       source index of snk_data
//   snk_last   out  1        word ends the burst (src_last or burst limit)
//   busy       out  1        a burst is open or a word is still held
// ---------------------------------------------------------------------------
module word_sink_arbiter
    import word_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               enable,
    input  logic [NREQ-1:0]    src_valid,
    input  logic [NREQ-1:0]    src_last,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    src_ready,
    output logic               snk_valid,
    input  logic               snk_ready,
    output logic [DW-1:0]      snk_data,
    output logic [TW-1:0]      snk_tag,
    output logic               snk_last,
    output logic               busy
);

    localparam logic [7:0]    CNT_LAST = 8'(MAX_BURST - 1);
    localparam logic [TW-1:0] GNT_MAX  = TW'(NREQ - 1);

    arb_state_t    state;
    logic [TW-1:0] ptr;
    logic [TW-1:0] gnt;
    logic [7:0]    cnt;

    logic          pick_any;
    logic [TW-1:0] pick_idx;
    logic [TW-1:0] ptr_next;
    logic          out_free;
    logic          gnt_valid;
    logic          gnt_last;
    logic [DW-1:0] gnt_word;
    logic          xfer;
    logic          xfer_last;

    rr_pick #(
        .NREQ (NREQ),
        .TW   (TW)
    ) u_pick (
        .req  (src_valid),
        .ptr  (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Output register can take a new word when empty or draining this cycle.
    assign out_free = !snk_valid || snk_ready;

    // Select the granted source's word, valid and last.
    always_comb begin
        gnt_word  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt == TW'(i)) begin
                gnt_word  = src_data[i*DW +: DW];
                gnt_valid = src_valid[i];
                gnt_last  = src_last[i];
            end
        end
    end

    // Ready is a function of state, enable and sink backpressure only, so a
    // source may wait for ready before raising valid without deadlock.
    always_comb begin
        src_ready = '0;
        if (state == BURST && enable && out_free) begin
            src_ready[gnt] = 1'b1;
        end
    end

    assign xfer      = (state == BURST) && enable && out_free && gnt_valid;
    assign xfer_last = gnt_last || (cnt == CNT_LAST);
    assign ptr_next  = (gnt == GNT_MAX) ? '0 : gnt + 1'b1;

    assign busy = (state != IDLE) || snk_valid;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            snk_valid <= 1'b0;
            snk_data  <= '0;
            snk_tag   <= '0;
            snk_last  <= 1'b0;
        end else begin
            // Drain first; a load in the same cycle below overrides it.
            if (snk_valid && snk_ready) begin
                snk_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && pick_any) begin
                        gnt   <= pick_idx;
                        cnt   <= '0;
                        state <= BURST;
                    end
                end

                BURST: begin
                    if (xfer) begin
                        snk_valid <= 1'b1;
                        snk_data  <= gnt_word;
                        snk_tag   <= gnt;
                        snk_last  <= xfer_last;
                        if (cnt != CNT_LAST) begin
                            cnt <= cnt + 8'd1;
                        end
                        if (xfer_last) begin
                            ptr   <= ptr_next;
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_sink_arbiter.sv
module tb_word_sink_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int MB   = 8;
    localparam int TW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstb;
    logic               enable;
    logic [NREQ-1:0]    src_valid;
    logic [NREQ-1:0]    src_last;
    logic [NREQ*DW-1:0] src_data;
    logic [NREQ-1:0]    src_ready;
    logic               snk_valid;
    logic               snk_ready;
    logic [DW-1:0]      snk_data;
    logic [TW-1:0]      snk_tag;
    logic               snk_last;
    logic               busy;

    word_sink_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MB),
        .TW        (TW)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .enable    (enable),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_data  (src_data),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .snk_data  (snk_data),
        .snk_tag   (snk_tag),
        .snk_last  (snk_last),
        .busy      (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: who owns the sink (-1 = nobody), where the next
    // round-robin search starts, words taken in this grant, held word.
    int              m_owner;
    int              m_ptr;
    int              m_taken;
    logic            m_ov;
    logic            m_ol;
    logic [DW-1:0]   m_od;
    int              m_ot;
    logic [NREQ-1:0] m_acc;

    logic [DW-1:0]   base [NREQ];
    int unsigned     seq  [NREQ];

    typedef struct {
        int            tag;
        logic          last;
        logic [DW-1:0] data;
    } obs_t;
    obs_t obs_q[$];

    logic [NREQ-1:0] rdy_seen;
    logic            sv_seen;

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (m_owner >= 0 && enable && (!m_ov || snk_ready)) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_taken = 0;
        m_ov    = 1'b0;
        m_ol    = 1'b0;
        m_od    = '0;
        m_ot    = 0;
        m_acc   = '0;
    endtask

    task automatic compare();
        rdy_seen = src_ready;
        sv_seen  = snk_valid;
        chk("src_ready", src_ready, exp_ready());
        chk("snk_valid", snk_valid, m_ov);
        chk("busy", busy, (m_owner >= 0) || m_ov);
        if (m_ov) begin
            chk("snk_data", snk_data, m_od);
            chk("snk_tag", snk_tag, m_ot);
            chk("snk_last", snk_last, m_ol);
        end
        if (snk_valid && snk_ready) obs_q.push_back('{int'(snk_tag), snk_last, snk_data});
    endtask

    task automatic update();
        logic found;
        int   cand;
        m_acc = exp_ready() & src_valid;
        if (m_ov && snk_ready) m_ov = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            if (enable) begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = (m_ptr + k) % NREQ;
                    if (!found && src_valid[cand]) begin
                        found   = 1'b1;
                        m_owner = cand;
                        m_taken = 0;
                    end
                end
            end
        end else if (m_acc != '0) begin
            m_ov = 1'b1;
            m_od = src_data[m_owner*DW +: DW];
            m_ot = m_owner;
            m_taken++;
            m_ol = src_last[m_owner] || (m_taken == MB);
            if (m_ol) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        for (int i = 0; i < NREQ; i++) if (m_acc[i]) seq[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) src_data[i*DW +: DW] = base[i] + DW'(seq[i]);
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        compare();
        update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb      = 1'b0;
        src_valid = '0;
        src_last  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    initial begin
        int   own_before;
        int   guard;
        logic [DW-1:0] held;

        enable    = 1'b1;
        snk_ready = 1'b1;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            base[i] = DW'(i * 16'h1000);
            seq[i]  = 0;
        end
        rstb = 1'b0;
        m_reset();
        #2;
        chk("rst_src_ready", src_ready, 0);
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_snk_data", snk_data, 0);
        chk("rst_snk_tag", snk_tag, 0);
        chk("rst_snk_last", snk_last, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Single source 2: three words, last on the third.
        base[2] = 16'hA001;
        obs_q.delete();
        for (int c = 0; c < 12; c++) begin
            src_valid = (seq[2] < 3) ? 4'b0100 : 4'b0000;
            src_last  = (seq[2] == 2) ? 4'b0100 : 4'b0000;
            step();
        end
        chk("single_count", obs_q.size(), 3);
        for (int k = 0; k < obs_q.size() && k < 3; k++) begin
            chk("single_data", obs_q[k].data, 16'hA001 + 16'(k));
            chk("single_tag", obs_q[k].tag, 2);
            chk("single_last", obs_q[k].last, k == 2);
        end

        // Wrap: pointer now 3, sources 0 and 3 request one-word packets.
        obs_q.delete();
        src_valid = 4'b1001;
        src_last  = 4'b1001;
        for (int c = 0; c < 6; c++) step();
        chk("wrap_count", obs_q.size() >= 2, 1);
        if (obs_q.size() >= 2) begin
            chk("wrap_first", obs_q[0].tag, 3);
            chk("wrap_second", obs_q[1].tag, 0);
        end

        // Continuous load from all sources, no last markers.
        do_reset();
        obs_q.delete();
        src_valid = '1;
        src_last  = '0;
        for (int c = 0; c < 46; c++) begin
            step();
            chk("gap_pattern", rdy_seen != '0, (c % 9) != 0);
        end
        chk("burst_words", obs_q.size(), 40);
        for (int k = 0; k < obs_q.size() && k < 40; k++) begin
            chk("burst_tag_last", {obs_q[k].tag[3:0], 3'b000, obs_q[k].last},
                {4'((k / 8) % 4), 3'b000, (k % 8) == 7});
        end

        // Backpressure mid-burst.
        for (int c = 0; c < 3; c++) step();
        snk_ready = 1'b0;
        step();
        held = m_od;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_ready", rdy_seen, 0);
            chk("bp_hold", snk_data, held);
        end
        snk_ready = 1'b1;
        for (int c = 0; c < 20; c++) step();

        // Enable drop while a word is held mid-burst.
        guard = 0;
        while (!(m_ov && m_owner >= 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("en_reach_hold", m_ov && m_owner >= 0, 1);
        own_before = m_owner;
        enable = 1'b0;
        step();
        chk("en_ready0", rdy_seen, 0);
        chk("en_drain_valid", sv_seen, 1);
        step();
        chk("en_drained", sv_seen, 0);
        step();
        chk("en_ready2", rdy_seen, 0);
        enable = 1'b1;
        step();
        chk("en_same_grant", rdy_seen, 4'b0001 << own_before);

        // Reset with a word held mid-burst.
        guard = 0;
        while (!(m_ov && m_owner >= 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_reach_hold", m_ov && m_owner >= 0, 1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_valid", snk_valid, 0);
        chk("mid_rst_data", snk_data, 0);
        chk("mid_rst_tag", snk_tag, 0);
        chk("mid_rst_last", snk_last, 0);
        chk("mid_rst_ready", src_ready, 0);
        chk("mid_rst_busy", busy, 0);
        m_reset();
        @(negedge clk);
        chk("mid_rst_ready_hold", src_ready, 0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        obs_q.delete();
        for (int c = 0; c < 3; c++) step();
        chk("post_rst_count", obs_q.size() >= 1, 1);
        if (obs_q.size() >= 1) chk("post_rst_tag", obs_q[0].tag, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            src_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) src_last[i] = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            snk_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_sink_arbiter.md
# word_sink_arbiter

Round-robin arbiter that shares one 16-bit word sink, such as the results-log writer, between NREQ independent word sources. It grants one source at a time for a bounded burst and forwards the granted words through a single registered output stage. Each word carries its source tag. In funcsim it sits between the DUT-side word producers and the single logging sink. Its ready/valid protocol and `enable` gate match that sink's.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DW, 16: data word width.
- MAX_BURST, 8: maximum words per grant, 1..255.
- TW, $clog2(NREQ): tag width.

- clk  in  1  single clock, all state on rising edge.
- rstb  in  1  asynchronous, active-low reset.
- enable  in  1  global gate; low blocks new source acceptance.
- src_valid  in  NREQ  per-source word valid.
- src_last  in  NREQ  per-source end-of-packet marker, qualified by valid.
- src_data  in  NREQ*DW  packed source words; source i occupies bits [i*DW +: DW].
- src_ready  out  NREQ  per-source accept; at most one bit set.
- snk_valid  out  1  registered output word valid.
- snk_ready  in  1  sink accept.
- snk_data  out  DW  registered output word.
- snk_tag  out  TW  index of the source that produced snk_data.
- snk_last  out  1  word ends the burst, by src_last or by the burst limit.
- busy  out  1  high whenever the state is not IDLE or snk_valid is high.

## Operation
- States: IDLE, BURST.
- IDLE:
  - If `enable` is high and any `src_valid` is high, pick the first requester at or after `ptr` in round-robin order.
  - Register it as `gnt`, clear `cnt`, and go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - src_ready[gnt] = enable & (!snk_valid | snk_ready). All other src_ready bits are 0.
  - A source transfer happens when src_valid[gnt] & src_ready[gnt] are both high. On a transfer:
    - load snk_data ← word, snk_tag ← gnt, snk_valid ← 1;
    - load snk_last ← src_last[gnt] | (cnt == MAX_BURST-1);
    - increment cnt.
  - If the transfer's snk_last term is 1, go to IDLE and set ptr ← (gnt+1) mod NREQ.
- Output stage:
  - When snk_valid & snk_ready and there is no new load, clear snk_valid.
  - Load and drain in the same cycle gives full throughput.
- When src_valid[gnt] drops mid-burst, stay in BURST and wait. The grant is held until the packet completes or MAX_BURST is reached.
- When `enable` goes low mid-burst:
  - stay in BURST and accept no new words;
  - the output stage still drains to the sink.
- cnt is 8 bits and saturates logically at MAX_BURST-1. It never wraps within a burst.
- ptr wraps from NREQ-1 to 0.
- Reset asserted mid-operation:
  - abandon the in-flight burst and drop the held word;
  - no src_ready pulse may occur during reset.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, gnt = 0, cnt = 0;
  - snk_valid = 0, snk_data = 0, snk_tag = 0, snk_last = 0;
  - src_ready = 0, busy = 0.
- Grant latency: a request seen in IDLE at edge N gives src_ready high during the cycle after edge N.
- Source-to-sink latency: a word accepted at edge N appears on snk_data/snk_valid after edge N.
- Inter-burst gap: exactly one IDLE cycle with no source accept. Throughput is MAX_BURST words per MAX_BURST+1 cycles under continuous load with snk_ready=1.
- With snk_ready=0 and snk_valid=1, src_ready is 0 and the output holds stable. This is the standard valid/ready rule: data and tag must not change while valid & !ready.
- src_ready depends combinationally on snk_ready and enable only. It never depends on src_valid.

## Structure
- Package `word_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, BURST};
  - the default DW and MAX_BURST localparams.
- Sub-module `rr_pick`: combinational, NREQ-wide round-robin first-set finder.
  - Inputs: req, ptr.
  - Outputs: any, idx.
  - Instantiated once.
- The FSM, counter and output register live in the top module.

## Test plan
- Single source: src 2 sends 3 words 0xA001..0xA003, last on the 3rd, snk_ready=1 → sink sees A001, A002, A003 with tag 2; snk_last only on A003; ptr=3 afterwards.
- All 4 sources valid continuously, never asserting last, MAX_BURST=8 →
  - bursts of 8 words each, in tag order 0,1,2,3,0;
  - snk_last on every 8th word;
  - exactly one idle cycle between bursts.
- Backpressure: snk_ready held 0 for 5 cycles mid-burst → snk_data/snk_tag stable, src_ready=0 throughout, no word lost or duplicated; sequence resumes in order.
- Enable: drop `enable` for 3 cycles mid-burst with 1 word held → held word still drains, no new accepts, same grant resumes afterwards.
- Reset: assert rstb=0 mid-burst with snk_valid=1 → all outputs at their reset values immediately; after release the first grant goes to source 0.
- Wrap: ptr=3 with requests from sources 0 and 3 → source 3 is granted first, then source 0.
